// File: rtl/bin2bcd_pkg.sv
// Shared types and defaults for the double-dabble converter.
// Optional leading-zero skip helper exists only with BIN2BCD_SKIP_LZ_EN.
package bin2bcd_pkg;

  localparam int BIN_W_DEF  = 32;
  localparam int DIGITS_DEF = 10;
  localparam int LZ_W       = 64;

  typedef enum logic [1:0] {
    IDLE,
    OP,
    DONE
  } state_t;

`ifdef BIN2BCD_SKIP_LZ_EN
  // Leading zeros of the low w bits of v; returns w when all are zero.
  function automatic int unsigned lzc(
    input logic [LZ_W-1:0] v,
    input int unsigned     w
  );
    lzc = w;
    for (int unsigned i = 0; i < LZ_W; i++) begin
      if (i < w && v[i]) lzc = w - 1 - i;
    end
  endfunction
`endif

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: adds 3 to a digit of 5 or more.
// Ports: d_i raw BCD digit, d_o corrected digit (no carry out).
module bcd_digit_adj (
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);

  assign d_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;

endmodule

// File: rtl/binary_to_bcd_converter.sv
// Sequential shift-add-3 binary to packed BCD converter, one shift/clk.
// Ports: clk_i, reset_i (sync, high), start_i/ready_o/done_o handshake,
// binary_i operand, BCD_o registered result (digit 0 in [3:0]).
// Build option: BIN2BCD_SKIP_LZ_EN skips the operand's leading zeros.
module binary_to_bcd_converter
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W  = BIN_W_DEF,
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic [BIN_W-1:0]      binary_i,
  output logic                  ready_o,
  output logic                  done_o,
  output logic [4*DIGITS-1:0]   BCD_o
);

  localparam int BW = 4 * DIGITS;
  localparam int NW = $clog2(BIN_W + 1);

  state_t            state_q, state_d;
  logic [BIN_W-1:0]  bin_q, bin_d;
  logic [BW-1:0]     bcd_q, bcd_d;
  logic [BW-1:0]     out_q, out_d;
  logic [NW-1:0]     n_q, n_d;
  logic [BW-1:0]     adj;
  logic [BW+BIN_W-1:0] shl;
  logic [BIN_W-1:0]  bin_load;
  logic [NW-1:0]     n_load;

  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    bcd_digit_adj u_adj (
      .d_i (bcd_q[4*i +: 4]),
      .d_o (adj[4*i +: 4])
    );
  end

  assign shl = {adj, bin_q} << 1;

`ifdef BIN2BCD_SKIP_LZ_EN
  logic [NW-1:0] lz;

  assign lz = NW'(lzc(LZ_W'(binary_i), BIN_W));
  assign bin_load = binary_i << lz;
  // An all-zero operand still needs one shift to reach DONE.
  assign n_load = (lz == NW'(BIN_W)) ? NW'(1)
                                     : NW'(BIN_W) - lz;
`else
  assign bin_load = binary_i;
  assign n_load   = NW'(BIN_W);
`endif

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    n_d     = n_q;
    out_d   = out_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          bin_d   = bin_load;
          bcd_d   = '0;
          n_d     = n_load;
          state_d = OP;
        end
      end
      OP: begin
        bcd_d = shl[BW+BIN_W-1:BIN_W];
        bin_d = shl[BIN_W-1:0];
        n_d   = n_q - NW'(1);
        if (n_q == NW'(1)) begin
          out_d   = shl[BW+BIN_W-1:BIN_W];
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      n_q     <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      n_q     <= n_d;
      out_q   <= out_d;
    end
  end

  assign ready_o = (state_q == IDLE);
  assign done_o  = (state_q == DONE);
  assign BCD_o   = out_q;

endmodule

// File: tb/tb_binary_to_bcd_converter.sv
// Self-checking bench for binary_to_bcd_converter.
// Reference: decimal digits via integer %/÷ arithmetic.
module tb_binary_to_bcd_converter;

  localparam int BIN_W  = 32;
  localparam int DIGITS = 10;

  logic                clk = 1'b0;
  logic                reset;
  logic                start;
  logic [BIN_W-1:0]    bin;
  logic                ready;
  logic                done;
  logic [4*DIGITS-1:0] bcd;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  binary_to_bcd_converter #(
    .BIN_W  (BIN_W),
    .DIGITS (DIGITS)
  ) dut (
    .clk_i    (clk),
    .reset_i  (reset),
    .start_i  (start),
    .binary_i (bin),
    .ready_o  (ready),
    .done_o   (done),
    .BCD_o    (bcd)
  );

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [4*DIGITS-1:0] bcd_ref(
    input longint unsigned v
  );
    logic [4*DIGITS-1:0] r;
    r = '0;
    for (int d = 0; d < DIGITS; d++) begin
      r[4*d +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic int exp_shifts(input logic [31:0] v);
`ifdef BIN2BCD_SKIP_LZ_EN
    int len;
    longint unsigned x;
    len = 0;
    x = v;
    while (x != 0) begin
      x = x / 2;
      len++;
    end
    return (len == 0) ? 1 : len;
`else
    return BIN_W;
`endif
  endfunction

  task automatic wait_ready(input string tag);
    int t;
    t = 0;
    while (!ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    chk({tag, " ready"}, 64'(ready), 64'd1);
  endtask

  task automatic convert(
    input logic [31:0] v,
    input int          hold,
    input string       tag
  );
    int lat, dcnt, pulses;
    bit ok;
    logic [4*DIGITS-1:0] e;
    e = bcd_ref(v);
    wait_ready(tag);
    @(negedge clk);
    start = 1'b1;
    bin   = v;
    @(posedge clk); #1;
    chk({tag, " busy"}, 64'(ready), 64'd0);
    lat = 0; dcnt = 0; ok = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      start = (c < hold);
      bin   = $urandom;
      @(posedge clk); #1;
      if (done) begin
        if (lat == 0) lat = c;
        dcnt++;
      end else if (lat != 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk({tag, " finished"}, 64'(ok), 64'd1);
    chk({tag, " latency"}, 64'(lat), 64'(exp_shifts(v)));
    chk({tag, " pulse"}, 64'(dcnt), 64'd1);
    chk({tag, " bcd"}, 64'(bcd), 64'(e));
    chk({tag, " idle"}, 64'(ready), 64'd1);
    pulses = 0;
    repeat (4) begin
      @(posedge clk); #1;
      pulses += int'(done);
    end
    chk({tag, " extra"}, 64'(pulses), 64'd0);
    chk({tag, " hold"}, 64'(bcd), 64'(e));
  endtask

  task automatic back_to_back(input logic [31:0] v);
    int t1, t2, rdy;
    wait_ready("b2b");
    t1 = 0; t2 = 0; rdy = 0;
    @(negedge clk);
    start = 1'b1;
    bin   = v;
    for (int c = 1; c <= 300; c++) begin
      @(posedge clk); #1;
      if (done) begin
        if (t1 == 0) begin
          t1 = c;
          chk("b2b bcd1", 64'(bcd), 64'(bcd_ref(v)));
        end else if (t2 == 0) begin
          t2 = c;
          chk("b2b bcd2", 64'(bcd), 64'(bcd_ref(v)));
          break;
        end
      end else if (t1 != 0 && ready) begin
        rdy++;
      end
    end
    @(negedge clk);
    start = 1'b0;
    chk("b2b seen", 64'(t2 != 0), 64'd1);
    chk("b2b gap", 64'(t2 - t1), 64'(exp_shifts(v) + 2));
    chk("b2b ready", 64'(rdy), 64'd1);
    wait_ready("b2b end");
  endtask

  task automatic mid_reset(input logic [31:0] v);
    int pulses;
    wait_ready("rst");
    @(negedge clk);
    start = 1'b1;
    bin   = v;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst ready", 64'(ready), 64'd1);
    chk("rst done", 64'(done), 64'd0);
    chk("rst bcd", 64'(bcd), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(posedge clk); #1;
      pulses += int'(done);
    end
    chk("rst nodone", 64'(pulses), 64'd0);
    chk("rst bcd held", 64'(bcd), 64'd0);
  endtask

  initial begin
    logic [31:0] r;
    reset = 1'b1;
    start = 1'b0;
    bin   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset ready", 64'(ready), 64'd1);
    chk("reset done", 64'(done), 64'd0);
    chk("reset bcd", 64'(bcd), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    convert(32'h10, 2, "h10");
    chk("h10 const", 64'(bcd), 64'h16);
    convert(32'hFFFF_FFFF, 1, "max");
    chk("max const", 64'(bcd), 64'h42_9496_7295);
    convert(32'h0, 1, "zero");
    convert(32'd12345678, 1, "dec");
    chk("dec const", 64'(bcd), 64'h00_1234_5678);
    back_to_back(32'd12345678);
    convert(32'd99999, 3, "nines");
    for (int i = 0; i < 8; i++) begin
      r = $urandom;
      r = r >> $urandom_range(0, 31);
      convert(r, 1, $sformatf("rnd%0d", i));
    end
    mid_reset($urandom | 32'h8000_0000);
    convert(32'd40960, 1, "post");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
